uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
Transmit-side buffer placed directly upstream of the UART transmitter. The system writes bytes at any rate. The block queues them and presents them to the transmitter through the DATA/DATARDY/READ handshake. DATA is held stable for the whole serial frame until the transmitter requests the next word.

Parameters:
DATAWIDTH, 8, width of each queued word and of DATA
DEPTH_LOG2, 4, log2 of FIFO depth (default depth 16 words)

Ports:
CLK  input  1  system clock
RST  input  1  synchronous, active-high reset
WR_EN  input  1  write strobe from system; one word per cycle while high
WR_DATA  input  DATAWIDTH  word to enqueue
FULL  output  1  high when COUNT == 2**DEPTH_LOG2
EMPTY  output  1  high when COUNT == 0
COUNT  output  DEPTH_LOG2+1  number of queued words, excluding the hold register
OVERFLOW  output  1  sticky; set when a write is dropped
CLR_OVF  input  1  clears OVERFLOW
DATA  output  DATAWIDTH  word currently handed to transmitter (hold register)
DATARDY  output  1  word available for transmitter; equals !EMPTY
READ  input  1  transmitter request; may stay high for more than one cycle

Behaviour:
- Reset is decided: RST is synchronous and active-high; the clock is CLK.
- Reset values: COUNT=0, pointers=0, FULL=0, EMPTY=1, DATARDY=0, DATA=0, OVERFLOW=0, read_d=0.
- RST mid-operation discards all queued words and the hold register, with no partial pop.
- Storage is a circular buffer of 2**DEPTH_LOG2 entries with wr_ptr and rd_ptr of DEPTH_LOG2 bits each. Pointers wrap naturally modulo depth.
- Write: on a CLK edge with WR_EN=1 and FULL=0, mem[wr_ptr] <= WR_DATA and wr_ptr increments.
- FULL is the registered state. A write while FULL=1 is dropped, even if a pop happens the same cycle. A dropped write sets OVERFLOW.
- Pop trigger: read_d is READ registered, and a pop is requested when READ=1 && read_d=0 (rising edge only).
  - READ held high for N cycles produces exactly one pop.
- Pop with EMPTY=0: DATA <= mem[rd_ptr] and rd_ptr increments.
  - DATA is valid from the cycle after the edge.
  - DATA stays unchanged until the next accepted pop.
- Pop with EMPTY=1: ignored. DATA, rd_ptr and COUNT are unchanged. No error flag is raised.
- COUNT update each cycle:
  - +1 on an accepted write only.
  - -1 on an accepted pop only.
  - Unchanged when both occur in the same cycle, including at COUNT=1, where the pop reads the old head and the new word remains.
- Write to an empty FIFO: DATARDY rises the cycle after the write edge, giving one cycle of latency.
- Pop of the last word: DATARDY falls the cycle after the pop edge.
- FULL, EMPTY and DATARDY are decoded combinationally from the registered COUNT.
- OVERFLOW:
  - Set on a dropped write.
  - Cleared by CLR_OVF.
  - If both happen in the same cycle, set wins.

Decomposition:
- Shared package uart_pkg holds the DATAWIDTH default (8) and the FIFO depth default constant. These are shared with the transmitter and with a future receiver FIFO.
- One sub-module, uart_fifo_mem: a 2**DEPTH_LOG2 x DATAWIDTH array with synchronous write and asynchronous read.
- Pointer, count, edge-detect and hold-register logic stay in uart_tx_fifo.

Test Plan:
- Reset, then write 0xA5 at cycle 0 -> DATARDY=1 and COUNT=1 at cycle 1. Pulse READ high for 3 cycles -> exactly one pop, DATA=0xA5 held, COUNT=0, DATARDY=0.
- Write 0x01..0x10 back-to-back (16 words) -> FULL=1, COUNT=16. A 17th write of 0x11 is dropped and OVERFLOW=1. Eight READ pulses -> DATA sequence 0x01..0x08, COUNT=8.
- Fill to 16, drain all 16, refill with 0x20..0x2F, drain -> DATA 0x20..0x2F in order, confirming pointer wrap-around.
- COUNT=1 (0x55 queued), then WR_EN with 0x66 and a READ rising edge in the same cycle -> DATA=0x55, COUNT stays 1, and the next pop yields 0x66.
- EMPTY=1 with DATA=0x77 from a previous pop, then pulse READ -> DATA stays 0x77, COUNT stays 0, pointers unchanged.
- Queue 3 words, assert RST for one cycle while READ is high -> COUNT=0, DATA=0, DATARDY=0, and OVERFLOW cleared. A subsequent write of 0x3C pops as 0x3C.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared UART constants. Word width and FIFO depth defaults are common to
//   the transmitter, the transmit FIFO and the planned receive FIFO.
package uart_pkg;

  localparam int UART_DATAWIDTH       = 8;
  localparam int UART_FIFO_DEPTH_LOG2 = 4;

endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem
//   2**DEPTH_LOG2 x DATAWIDTH storage array. Synchronous write, asynchronous
//   read. No reset: the pointers and count in the owner decide which entries
//   are meaningful.
// Ports:
//   CLK      clock
//   i_we     write enable
//   i_waddr  write address
//   i_wdata  write data
//   i_raddr  read address
//   o_rdata  read data (combinational from i_raddr)
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DATAWIDTH  = UART_DATAWIDTH,
  parameter int DEPTH_LOG2 = UART_FIFO_DEPTH_LOG2
) (
  input  logic                  CLK,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_waddr,
  input  logic [DATAWIDTH-1:0]  i_wdata,
  input  logic [DEPTH_LOG2-1:0] i_raddr,
  output logic [DATAWIDTH-1:0]  o_rdata
);

  logic [DATAWIDTH-1:0] r_mem [2**DEPTH_LOG2];

  always_ff @(posedge CLK) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Transmit buffer in front of the UART transmitter. Bytes are queued at any
//   rate and handed to the transmitter through a hold register (DATA) that is
//   reloaded only on the rising edge of READ, so DATA stays stable for the
//   whole serial frame.
// Ports:
//   CLK, RST   clock, synchronous active-high reset
//   WR_EN      write strobe, one word per cycle while high
//   WR_DATA    word to enqueue
//   FULL       COUNT == depth
//   EMPTY      COUNT == 0
//   COUNT      queued words, not counting the hold register
//   OVERFLOW   sticky flag, set when a write is dropped
//   CLR_OVF    clears OVERFLOW (a simultaneous drop wins)
//   DATA       hold register presented to the transmitter
//   DATARDY    word available (= !EMPTY)
//   READ       transmitter request; only its rising edge pops
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATAWIDTH  = UART_DATAWIDTH,
  parameter int DEPTH_LOG2 = UART_FIFO_DEPTH_LOG2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  WR_EN,
  input  logic [DATAWIDTH-1:0]  WR_DATA,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic [DEPTH_LOG2:0]   COUNT,
  output logic                  OVERFLOW,
  input  logic                  CLR_OVF,
  output logic [DATAWIDTH-1:0]  DATA,
  output logic                  DATARDY,
  input  logic                  READ
);

  localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic [DATAWIDTH-1:0]  r_data;
  logic                  r_read_d;
  logic                  r_ovf;

  logic                  w_full, w_empty;
  logic                  w_wr_acc, w_wr_drop, w_pop_acc;
  logic [DATAWIDTH-1:0]  w_rdata;

  // Flags decode from the registered count only, so a write to a full FIFO
  // is dropped even when a pop frees a slot in the same cycle.
  assign w_full    = (r_count == CNT_FULL);
  assign w_empty   = (r_count == '0);
  assign w_wr_acc  = WR_EN && !w_full;
  assign w_wr_drop = WR_EN &&  w_full;
  assign w_pop_acc = READ && !r_read_d && !w_empty;

  uart_fifo_mem #(
    .DATAWIDTH  (DATAWIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .CLK     (CLK),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr),
    .i_wdata (WR_DATA),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_data   <= '0;
      r_read_d <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_read_d <= READ;
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      // Asynchronous read gives the old head even if a write lands in the
      // same cycle (at COUNT=1 the write targets a different slot).
      if (w_pop_acc) begin
        r_data   <= w_rdata;
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_wr_acc, w_pop_acc})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (w_wr_drop)    r_ovf <= 1'b1;
      else if (CLR_OVF) r_ovf <= 1'b0;
    end
  end

  assign FULL     = w_full;
  assign EMPTY    = w_empty;
  assign DATARDY  = !w_empty;
  assign COUNT    = r_count;
  assign OVERFLOW = r_ovf;
  assign DATA     = r_data;

endmodule
